// File: rtl/crc_feed_pkg.sv
// Shared types for the CRC32 byte feeder:
// bus size codes, FIFO entry layout and serializer states.
package crc_feed_pkg;

   localparam logic [1:0] WR_B    = 2'b00;
   localparam logic [1:0] WR_H    = 2'b01;
   localparam logic [1:0] WR_W    = 2'b10;
   localparam logic [1:0] WR_NONE = 2'b11;

   // FIFO entry: {nbytes[2:0], data[31:0]}
   localparam int ENT_W = 35;

   typedef enum logic {
      IDLE,
      SHIFT
   } state_t;

   function automatic logic [2:0] nbytes_of(
      input logic [1:0] sz
   );
      logic [2:0] n;
      n = 3'd0;
      unique case (sz)
         WR_B:    n = 3'd1;
         WR_H:    n = 3'd2;
         WR_W:    n = 3'd4;
         default: n = 3'd0;
      endcase
      return n;
   endfunction

   // Byte presented next: low byte, or the top valid byte
   function automatic logic [7:0] sel_byte(
      input logic [31:0] d,
      input logic [2:0]  n,
      input logic        msb
   );
      logic [7:0] b;
      b = d[7:0];
      if (msb) begin
         unique case (n)
            3'd2:    b = d[15:8];
            3'd4:    b = d[31:24];
            default: b = d[7:0];
         endcase
      end
      return b;
   endfunction

endpackage

// File: rtl/crc_feed_fifo.sv
// Word FIFO between CPU writes and the byte serializer.
// Combinational head read, flush clears pointers and level.
module crc_feed_fifo
   import crc_feed_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int LVL_W = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             push,
   input  logic             pop,
   input  logic [ENT_W-1:0] din,
   output logic [ENT_W-1:0] dout,
   output logic             full,
   output logic             empty,
   output logic [LVL_W-1:0] level
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [ENT_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (level == LVL_W'(DEPTH));
   assign empty   = (level == '0);
   assign do_push = push & ~full & ~flush;
   assign do_pop  = pop & ~empty & ~flush;
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= din;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         unique case ({do_push, do_pop})
            2'b10:   level <= level + LVL_W'(1);
            2'b01:   level <= level - LVL_W'(1);
            default: level <= level;
         endcase
      end
   end

endmodule

// File: rtl/crc_byte_feeder.sv
// CRC32 upstream stage: buffers 8/16/32-bit writes and
// serializes them into a valid/ready byte stream.
module crc_byte_feeder
   import crc_feed_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int LVL_W = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [1:0]       wr_size,
   input  logic [31:0]      wr_data,
   input  logic             msb_first,
   input  logic             flush,
   input  logic             clr_ovf,
   input  logic             byte_ready,
   output logic             byte_valid,
   output logic [7:0]       byte_data,
   output logic             byte_last,
   output logic             wr_ready,
   output logic [LVL_W-1:0] level,
   output logic             busy,
   output logic             overflow
);

   logic             push_req;
   logic             full;
   logic             empty;
   logic             take;
   logic             load;
   logic             xfer;
   logic [ENT_W-1:0] head;
   logic [31:0]      hd_data;
   logic [2:0]       hd_nb;

   state_t      state;
   logic [31:0] sh;
   logic [31:0] sh_nx;
   logic [2:0]  cnt;
   logic [2:0]  nb;
   logic        msb;

   assign push_req = (wr_size != WR_NONE);
   assign xfer     = byte_valid & byte_ready;
   assign take     = (state == IDLE) |
                     (xfer & (cnt == 3'd1));
   assign load     = take & ~empty & ~flush;
   assign hd_data  = head[31:0];
   assign hd_nb    = head[34:32];
   assign sh_nx    = msb ? (sh << 8) : (sh >> 8);
   assign wr_ready = ~full;
   assign busy     = byte_valid | (level != '0);

   crc_feed_fifo #(
      .DEPTH (DEPTH),
      .LVL_W (LVL_W)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (flush),
      .push  (push_req),
      .pop   (load),
      .din   ({nbytes_of(wr_size), wr_data}),
      .dout  (head),
      .full  (full),
      .empty (empty),
      .level (level)
   );

   always_ff @(posedge clk) begin
      if (!rst_n || flush) begin
         state      <= IDLE;
         sh         <= '0;
         cnt        <= '0;
         nb         <= '0;
         msb        <= 1'b0;
         byte_valid <= 1'b0;
         byte_data  <= '0;
         byte_last  <= 1'b0;
      end else if (load) begin
         // back-to-back reload keeps the stream bubble-free
         state      <= SHIFT;
         sh         <= hd_data;
         cnt        <= hd_nb;
         nb         <= hd_nb;
         msb        <= msb_first;
         byte_valid <= 1'b1;
         byte_data  <= sel_byte(hd_data, hd_nb, msb_first);
         byte_last  <= (hd_nb == 3'd1);
      end else if (state == SHIFT && xfer) begin
         if (cnt == 3'd1) begin
            state      <= IDLE;
            cnt        <= '0;
            byte_valid <= 1'b0;
            byte_last  <= 1'b0;
         end else begin
            sh         <= sh_nx;
            cnt        <= cnt - 3'd1;
            byte_data  <= sel_byte(sh_nx, nb, msb);
            byte_last  <= (cnt == 3'd2);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         overflow <= 1'b0;
      end else if (push_req & full & ~flush) begin
         overflow <= 1'b1;
      end else if (clr_ovf) begin
         overflow <= 1'b0;
      end
   end

endmodule
